// File: rtl/icache_fill_fsm.sv
// icache_fill_fsm: I-cache miss handler, fetches an 8-word block, writes data then tag.
// Optional ICACHE_FILL_CRITICAL_WORD_FIRST_EN: fetch starts at the missed word and wraps.
`default_nettype none

module icache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_detected,
   input  logic [ADDR_WIDTH-1:0] miss_address,
   output logic                  fsm_busy,
   output logic                  memory_en,
   output logic [ADDR_WIDTH-1:0] memory_address,
   input  logic                  memory_data_valid,
   input  logic [15:0]           memory_data_in,
   output logic                  write_data_array,
   output logic                  write_tag_array,
   output logic [ADDR_WIDTH-1:0] cache_addr,
   output logic [15:0]           cache_data
);

   localparam int CNT_W = $clog2(BLOCK_WORDS);
   localparam int OFF_W = CNT_W + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_TAG  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]      req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]      rcv_cnt_q, rcv_cnt_d;
   logic [CNT_W-1:0]      start_q, start_d;
   logic                  req_done_q, req_done_d;

   logic [CNT_W-1:0]      req_off;
   logic [CNT_W-1:0]      rcv_off;
   logic                  unused_addr_bits;

   // Word offsets wrap inside the block, so the tag bits of base never change.
   assign req_off = start_q + req_cnt_q;
   assign rcv_off = start_q + rcv_cnt_q;
   assign unused_addr_bits = ^miss_address[OFF_W-1:0];

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      req_cnt_d        = req_cnt_q;
      rcv_cnt_d        = rcv_cnt_q;
      start_d          = start_q;
      req_done_d       = req_done_q;
      fsm_busy         = 1'b0;
      memory_en        = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      cache_addr       = '0;
      cache_data       = '0;

      case (state_q)
         S_IDLE: begin
            if (miss_detected) begin
               base_d     = {miss_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
               req_cnt_d  = '0;
               rcv_cnt_d  = '0;
               req_done_d = 1'b0;
`ifdef ICACHE_FILL_CRITICAL_WORD_FIRST_EN
               start_d    = miss_address[OFF_W-1:1];
`else
               start_d    = '0;
`endif
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            fsm_busy = 1'b1;
            if (!req_done_q) begin
               memory_en      = 1'b1;
               memory_address = {base_q[ADDR_WIDTH-1:OFF_W], req_off, 1'b0};
               req_cnt_d      = req_cnt_q + CNT_ONE;
               if (req_cnt_q == CNT_LAST) begin
                  req_done_d = 1'b1;
               end
            end
            if (memory_data_valid) begin
               write_data_array = 1'b1;
               cache_data       = memory_data_in;
               cache_addr       = {base_q[ADDR_WIDTH-1:OFF_W], rcv_off, 1'b0};
               rcv_cnt_d        = rcv_cnt_q + CNT_ONE;
               if (rcv_cnt_q == CNT_LAST) begin
                  state_d = S_TAG;
               end
            end
         end
         S_TAG: begin
            fsm_busy        = 1'b1;
            write_tag_array = 1'b1;
            cache_addr      = base_q;
            state_d         = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         req_cnt_q  <= '0;
         rcv_cnt_q  <= '0;
         start_q    <= '0;
         req_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         req_cnt_q  <= req_cnt_d;
         rcv_cnt_q  <= rcv_cnt_d;
         start_q    <= start_d;
         req_done_q <= req_done_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_icache_fill_fsm.sv
// Directed self-checking bench for icache_fill_fsm with an in-order, variable-latency memory model.
`default_nettype none

module tb_icache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = '0;
   logic        fsm_busy;
   logic        memory_en;
   logic [15:0] memory_address;
   logic        memory_data_valid = 1'b0;
   logic [15:0] memory_data_in = '0;
   logic        write_data_array;
   logic        write_tag_array;
   logic [15:0] cache_addr;
   logic [15:0] cache_data;

   int tests = 0;
   int failures = 0;

   wire [51:0] outs = {fsm_busy, memory_en, write_data_array, write_tag_array,
                       memory_address, cache_addr, cache_data};

   always #5 clk = ~clk;

   icache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_WIDTH(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .miss_detected    (miss_detected),
      .miss_address     (miss_address),
      .fsm_busy         (fsm_busy),
      .memory_en        (memory_en),
      .memory_address   (memory_address),
      .memory_data_valid(memory_data_valid),
      .memory_data_in   (memory_data_in),
      .write_data_array (write_data_array),
      .write_tag_array  (write_tag_array),
      .cache_addr       (cache_addr),
      .cache_data       (cache_data)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; miss_detected = 1'b0; memory_data_valid = 1'b0; memory_data_in = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (outs !== 52'd0) begin
         failures++; $display("FAIL reset_outputs got %h want 0", outs);
      end
      rst = 1'b0;
   endtask

   task automatic test_stray_valid();
      bit bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         memory_data_valid = 1'b1; memory_data_in = 16'hBEEF;
         #1;
         if (outs !== 52'd0) bad = 1'b1;
      end
      @(negedge clk);
      memory_data_valid = 1'b0;
      #1;
      tests++;
      if (bad) begin
         failures++; $display("FAIL stray_valid_idle got write/busy activity want none");
      end
      tests++;
      if (outs !== 52'd0) begin
         failures++; $display("FAIL stray_valid_after got %h want 0", outs);
      end
   endtask

   // Runs one complete fill and checks request/write/tag sequences against the expected order.
   task automatic run_fill(input string name, input logic [15:0] maddr, input logic [15:0] exp_base,
                           input int exp_start, input int lat, input logic [31:0] allow,
                           input bit hold_miss);
      logic [15:0] exp_a [8];
      logic [15:0] q_addr [$];
      int          q_due [$];
      int nreq = 0, nwr = 0, ntag = 0, tag_wr = 0;
      bit done = 1'b0, ord_ok = 1'b1, waddr_ok = 1'b1, dat_ok = 1'b1, busy_ok = 1'b1;
      logic        tag_with_data = 1'b0;
      logic [15:0] tag_addr = '0;

      for (int i = 0; i < 8; i++) exp_a[i] = exp_base + 16'(((exp_start + i) % 8) * 2);

      @(negedge clk);
      miss_detected = 1'b1; miss_address = maddr; memory_data_valid = 1'b0;
      #1;
      tests++;
      if (fsm_busy !== 1'b0 || memory_en !== 1'b0) begin
         failures++; $display("FAIL %s idle_before busy=%b en=%b want 0 0", name, fsm_busy, memory_en);
      end

      for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
         @(negedge clk);
         miss_detected = hold_miss;
         if (hold_miss) miss_address = 16'h4444;
         memory_data_valid = 1'b0; memory_data_in = '0;
         if (q_addr.size() > 0 && q_due[0] <= cyc && allow[cyc % 32]) begin
            memory_data_valid = 1'b1;
            memory_data_in = q_addr[0] ^ 16'hA5A5;
            void'(q_addr.pop_front()); void'(q_due.pop_front());
         end else if (q_addr.size() == 0 && nwr == 8) begin
            memory_data_valid = 1'b1; memory_data_in = 16'hDEAD;
         end
         #1;
         if (fsm_busy !== 1'b1) busy_ok = 1'b0;
         if (memory_en === 1'b1) begin
            if (nreq >= 8 || memory_address !== exp_a[nreq]) ord_ok = 1'b0;
            q_addr.push_back(memory_address); q_due.push_back(cyc + lat);
            nreq++;
         end
         if (write_data_array === 1'b1) begin
            if (nwr >= 8 || cache_addr !== exp_a[nwr]) waddr_ok = 1'b0;
            else if (cache_data !== (exp_a[nwr] ^ 16'hA5A5)) dat_ok = 1'b0;
            nwr++;
         end
         if (write_tag_array === 1'b1) begin
            ntag++; tag_addr = cache_addr; tag_wr = nwr; tag_with_data = write_data_array;
            done = 1'b1;
         end
      end

      tests++;
      if (!done) begin failures++; $display("FAIL %s tag_timeout got no tag write want one", name); end
      tests++;
      if (nreq != 8) begin failures++; $display("FAIL %s req_count got %0d want 8", name, nreq); end
      tests++;
      if (!ord_ok) begin failures++; $display("FAIL %s req_order got wrong address want base %h start %0d", name, exp_base, exp_start); end
      tests++;
      if (tag_wr != 8) begin failures++; $display("FAIL %s writes_before_tag got %0d want 8", name, tag_wr); end
      tests++;
      if (!waddr_ok) begin failures++; $display("FAIL %s write_addr_order got wrong address want base %h start %0d", name, exp_base, exp_start); end
      tests++;
      if (!dat_ok) begin failures++; $display("FAIL %s write_data got wrong word want addr^A5A5", name); end
      tests++;
      if (tag_addr !== exp_base) begin failures++; $display("FAIL %s tag_addr got %h want %h", name, tag_addr, exp_base); end
      tests++;
      if (tag_with_data !== 1'b0) begin failures++; $display("FAIL %s tag_cycle_data_write got %b want 0", name, tag_with_data); end
      tests++;
      if (!busy_ok) begin failures++; $display("FAIL %s busy_during_fill got low want high", name); end

      @(negedge clk);
      miss_detected = hold_miss; miss_address = maddr;
      memory_data_valid = 1'b1; memory_data_in = 16'hDEAD;
      #1;
      tests++;
      if (outs !== 52'd0) begin failures++; $display("FAIL %s idle_after_tag got %h want 0", name, outs); end

      if (hold_miss) begin
         @(negedge clk);
         miss_detected = 1'b0; memory_data_valid = 1'b0;
         #1;
         tests++;
         if (fsm_busy !== 1'b1 || memory_en !== 1'b1 || memory_address !== exp_a[0]) begin
            failures++;
            $display("FAIL %s refill_start got busy=%b en=%b addr=%h want 1 1 %h",
                     name, fsm_busy, memory_en, memory_address, exp_a[0]);
         end
      end
      memory_data_valid = 1'b0;
      apply_reset();
   endtask

   task automatic test_reset_mid_fill();
      logic [15:0] q_addr [$];
      int          q_due [$];
      int nwr = 0, cyc = 0, stray = 0;
      bit bad = 1'b0;

      @(negedge clk);
      miss_detected = 1'b1; miss_address = 16'h5678;
      while (nwr < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         miss_detected = 1'b0; memory_data_valid = 1'b0;
         if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            memory_data_valid = 1'b1; memory_data_in = q_addr[0];
            void'(q_addr.pop_front()); void'(q_due.pop_front());
         end
         #1;
         if (memory_en === 1'b1) begin q_addr.push_back(memory_address); q_due.push_back(cyc + 4); end
         if (write_data_array === 1'b1) nwr++;
      end
      tests++;
      if (nwr != 3) begin failures++; $display("FAIL rst_mid pre_writes got %0d want 3", nwr); end

      @(negedge clk);
      cyc++;
      rst = 1'b1; memory_data_valid = 1'b0;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         memory_data_valid = 1'b1; memory_data_in = q_addr[0];
         void'(q_addr.pop_front()); void'(q_due.pop_front());
      end
      #1;
      if (memory_en === 1'b1) begin q_addr.push_back(memory_address); q_due.push_back(cyc + 4); end

      @(negedge clk);
      cyc++;
      rst = 1'b0; memory_data_valid = 1'b0;
      #1;
      tests++;
      if (outs !== 52'd0) begin failures++; $display("FAIL rst_mid first_cycle got %h want 0", outs); end

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         cyc++;
         memory_data_valid = 1'b0;
         if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            memory_data_valid = 1'b1; memory_data_in = q_addr[0];
            void'(q_addr.pop_front()); void'(q_due.pop_front());
            stray++;
         end
         #1;
         if (outs !== 52'd0) bad = 1'b1;
      end
      memory_data_valid = 1'b0;
      tests++;
      if (stray == 0) begin failures++; $display("FAIL rst_mid late_returns got %0d want >0", stray); end
      tests++;
      if (bad) begin failures++; $display("FAIL rst_mid late_activity got writes/busy want none"); end
   endtask

   initial begin
      test_reset();
      test_stray_valid();
`ifdef ICACHE_FILL_CRITICAL_WORD_FIRST_EN
      run_fill("basic",     16'h1234, 16'h1230, 2, 4, 32'hFFFF_FFFF, 1'b0);
      run_fill("hold_miss", 16'h2000, 16'h2000, 0, 2, 32'hFFFF_FFFF, 1'b1);
      run_fill("irregular", 16'h8000, 16'h8000, 0, 3, 32'h0034_B0D0, 1'b0);
      run_fill("wrap",      16'hFFFE, 16'hFFF0, 7, 1, 32'hFFFF_FFFF, 1'b0);
      run_fill("cwf",       16'h123A, 16'h1230, 5, 4, 32'hFFFF_FFFF, 1'b0);
`else
      run_fill("basic",     16'h1234, 16'h1230, 0, 4, 32'hFFFF_FFFF, 1'b0);
      run_fill("hold_miss", 16'h2000, 16'h2000, 0, 2, 32'hFFFF_FFFF, 1'b1);
      run_fill("irregular", 16'h8000, 16'h8000, 0, 3, 32'h0034_B0D0, 1'b0);
      run_fill("wrap",      16'hFFFE, 16'hFFF0, 0, 1, 32'hFFFF_FFFF, 1'b0);
      run_fill("seq_123a",  16'h123A, 16'h1230, 0, 4, 32'hFFFF_FFFF, 1'b0);
`endif
      test_reset_mid_fill();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/icache_fill_fsm.md
Name: icache_fill_fsm

Overview:
- Miss handler for the 4-way instruction cache. It sits between the I-cache and the multicycle main memory.
- On a miss it fetches the whole 8-word (16-byte) block from memory, one request per cycle.
- Each returned word is written into the cache data array. The tag/valid/LRU metadata is written last, and the stall is then released.
- Outputs drive the cache's write_data_en / write_tag_en / addr_input / data_input on a fill.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block; power of two; fixes the counter width at log2(BLOCK_WORDS).
- ADDR_WIDTH, 16, byte-address width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- miss_detected  input  1  cache reports a miss on miss_address (IF_stall)
- miss_address  input  ADDR_WIDTH  byte address that missed
- fsm_busy  output  1  fill in progress; holds the fetch stage
- memory_en  output  1  one-cycle read request to memory
- memory_address  output  ADDR_WIDTH  request address
- memory_data_valid  input  1  memory returns one word this cycle, in request order
- memory_data_in  input  16  returned word
- write_data_array  output  1  write cache_data into the data array this cycle
- write_tag_array  output  1  write metadata (valid, LRU, tag) this cycle
- cache_addr  output  ADDR_WIDTH  address presented to the cache for the write
- cache_data  output  16  word presented to the cache

Behaviour:
- Reset: synchronous, active-high. Clears state to IDLE and all counters and the base register to 0. All outputs are 0 the cycle after rst is sampled high.
- States: IDLE, FILL, TAG.
- IDLE:
  - fsm_busy=0, no writes, memory_en=0.
  - memory_data_valid is ignored.
  - If miss_detected=1: latch base = miss_address with bits [3:0] cleared, clear req_cnt and rcv_cnt, go to FILL.
- FILL:
  - fsm_busy=1.
  - While req_cnt < BLOCK_WORDS: memory_en=1, memory_address = base + 2*req_cnt, then req_cnt increments. Requests go out on 8 consecutive cycles, starting the first FILL cycle.
  - After the last request, memory_en=0.
  - Each cycle with memory_data_valid=1: write_data_array=1, cache_data=memory_data_in, cache_addr = base + 2*rcv_cnt (combinational, same cycle), then rcv_cnt increments.
  - A request and a return in the same cycle are both handled.
  - When the 8th valid arrives (rcv_cnt=7 and valid), go to TAG.
- TAG:
  - Exactly one cycle: write_tag_array=1, cache_addr=base, fsm_busy=1, no data write.
  - Next state IDLE. fsm_busy falls so the cache re-looks-up and hits.
- Counter arithmetic: counters are 3 bits wide. Address math is modulo 2^ADDR_WIDTH, and offsets never carry past bit 3.
- miss_detected during FILL/TAG is ignored. No new fill can start in the TAG cycle.
- memory_data_valid in TAG or IDLE (stray or late) is ignored and produces no write.
- Reset mid-fill: abort immediately, back to IDLE. The partially written block stays invalid because its tag was never written. Returns still in flight are ignored.
- Memory latency is not assumed; the block relies only on in-order valid returns.

Optional Feature:
- Macro: ICACHE_FILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Latch start = miss_address[3:1].
  - Request i goes to base + 2*((start+i) mod 8).
  - Return j is written to base + 2*((start+j) mod 8).
  - The offset wraps within the block. Tag is still written last.
- Undefined: start is fixed at 0, giving the sequential order above. No extra ports either way.

Test Plan:
- Basic fill, memory latency 4: miss_detected with miss_address=0x1234 → memory_en high for 8 cycles with addresses 0x1230, 0x1232, …, 0x123E. Eight write_data_array pulses with cache_addr 0x1230…0x123E and the matching data. Then one write_tag_array pulse with cache_addr=0x1230. fsm_busy deasserts the following cycle.
- Stray and repeated inputs: memory_data_valid pulsed in IDLE → no write, fsm_busy=0. miss_detected held high for the whole fill → exactly one fill of 8 requests; a new fill starts only in the cycle after TAG.
- Reset mid-fill: rst after the 3rd return → next cycle all outputs 0 and IDLE. The remaining 5 returns produce no writes and no tag write.
- Irregular memory valids: gaps between returns (e.g. valid on cycles 4, 6, 7, 12, …) → writes track rcv_cnt in order. TAG is entered only after the 8th valid.
- Address wrap: miss_address=0xFFFE → base 0xFFF0, requests 0xFFF0…0xFFFE, no carry into the tag bits.
- With ICACHE_FILL_CRITICAL_WORD_FIRST_EN: miss_address=0x123A → request order 0x123A, 0x123C, 0x123E, 0x1230, …, 0x1238. Writes follow the same order; tag written last.
